// File: rtl/counter_down_timer.sv
// Loadable down-counting timeout timer.
// Counts a loaded value down to zero at a prescaled rate. When the count
// reaches zero it pulses expired, then either stops with a sticky done flag
// or reloads and keeps running (auto_reload).
module counter_down_timer #(
   parameter int WIDTH      = 32,
   parameter int PRESCALE_W = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cl,
   input  logic                  w,
   input  logic [WIDTH-1:0]      d,
   input  logic                  start,
   input  logic                  pause,
   input  logic                  auto_reload,
   input  logic [PRESCALE_W-1:0] prescale,
   output logic [WIDTH-1:0]      q,
   output logic                  busy,
   output logic                  expired,
   output logic                  done
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic [WIDTH-1:0]      Q_ZERO  = '0;
   localparam logic [WIDTH-1:0]      Q_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [PRESCALE_W-1:0] PC_ZERO = '0;
   localparam logic [PRESCALE_W-1:0] PC_ONE  = {{(PRESCALE_W-1){1'b0}}, 1'b1};

   state_t                  state;
   state_t                  state_n;
   logic [WIDTH-1:0]        reload;
   logic [WIDTH-1:0]        reload_n;
   logic [WIDTH-1:0]        q_n;
   logic [PRESCALE_W-1:0]   pc;
   logic [PRESCALE_W-1:0]   pc_n;
   logic                    done_n;
   logic                    expired_n;
   logic                    busy_n;

   // State and output registers; every output comes straight from a flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         q       <= Q_ZERO;
         reload  <= Q_ZERO;
         pc      <= PC_ZERO;
         busy    <= 1'b0;
         expired <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= state_n;
         q       <= q_n;
         reload  <= reload_n;
         pc      <= pc_n;
         busy    <= busy_n;
         expired <= expired_n;
         done    <= done_n;
      end
   end

   // Next-state logic, priority cl > w > start > pause/tick. A PAUSED timer
   // whose pause drops resumes counting on that same edge, so the countdown
   // advances on every busy edge where pause is low.
   always_comb begin
      state_n   = state;
      q_n       = q;
      reload_n  = reload;
      pc_n      = pc;
      done_n    = done;
      expired_n = 1'b0;

      if (cl) begin
         state_n  = IDLE;
         q_n      = Q_ZERO;
         reload_n = Q_ZERO;
         pc_n     = PC_ZERO;
         done_n   = 1'b0;
      end else if (w) begin
         state_n  = IDLE;
         q_n      = d;
         reload_n = d;
         pc_n     = PC_ZERO;
         done_n   = 1'b0;
      end else if (start && state == IDLE) begin
         if (q != Q_ZERO) begin
            state_n = RUN;
            pc_n    = PC_ZERO;
            done_n  = 1'b0;
         end else begin
            state_n   = DONE;
            expired_n = 1'b1;
            done_n    = 1'b1;
         end
      end else if (start && state == DONE) begin
         q_n  = reload;
         pc_n = PC_ZERO;
         if (reload != Q_ZERO) begin
            state_n = RUN;
            done_n  = 1'b0;
         end else begin
            state_n   = DONE;
            expired_n = 1'b1;
            done_n    = 1'b1;
         end
      end else if (state == RUN || state == PAUSED) begin
         if (pause) begin
            state_n = PAUSED;
         end else begin
            state_n = RUN;
            if (pc >= prescale) begin
               pc_n = PC_ZERO;
               if (q > Q_ONE) begin
                  q_n = q - Q_ONE;
               end else if (q == Q_ONE) begin
                  expired_n = 1'b1;
                  if (auto_reload && reload != Q_ZERO) begin
                     q_n = reload;
                  end else begin
                     q_n     = Q_ZERO;
                     done_n  = 1'b1;
                     state_n = DONE;
                  end
               end else begin
                  done_n  = 1'b1;
                  state_n = DONE;
               end
            end else begin
               pc_n = pc + PC_ONE;
            end
         end
      end

      busy_n = (state_n == RUN) || (state_n == PAUSED);
   end

endmodule

// File: tb/tb_counter_down_timer.sv
// Self-checking bench for counter_down_timer: directed scenarios followed by
// random stimulus, all compared against a behavioural model of the timer.
module tb_counter_down_timer;

   localparam int WIDTH      = 8;
   localparam int PRESCALE_W = 3;

   localparam int M_IDLE  = 0;
   localparam int M_COUNT = 1;
   localparam int M_FIN   = 2;

   logic                  clk;
   logic                  rst_n;
   logic                  cl;
   logic                  w;
   logic [WIDTH-1:0]      d;
   logic                  start;
   logic                  pause;
   logic                  auto_reload;
   logic [PRESCALE_W-1:0] prescale;
   logic [WIDTH-1:0]      q;
   logic                  busy;
   logic                  expired;
   logic                  done;

   int n_checks = 0;
   int n_fail   = 0;

   int m_mode;
   int m_q;
   int m_reload;
   int m_pc;
   int m_done;
   int m_exp;

   counter_down_timer #(
      .WIDTH(WIDTH),
      .PRESCALE_W(PRESCALE_W)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .cl(cl),
      .w(w),
      .d(d),
      .start(start),
      .pause(pause),
      .auto_reload(auto_reload),
      .prescale(prescale),
      .q(q),
      .busy(busy),
      .expired(expired),
      .done(done)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input int observed, input int expected);
      n_checks++;
      assert (observed === expected)
      else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic model_reset();
      m_mode   = M_IDLE;
      m_q      = 0;
      m_reload = 0;
      m_pc     = 0;
      m_done   = 0;
      m_exp    = 0;
   endtask

   // What one clock edge does to the timer, given the inputs seen at that edge.
   task automatic model_edge();
      m_exp = 0;
      if (cl) begin
         model_reset();
      end else if (w) begin
         m_q = int'(d); m_reload = int'(d); m_pc = 0; m_done = 0; m_mode = M_IDLE;
      end else if (start && m_mode == M_IDLE) begin
         if (m_q != 0) begin
            m_mode = M_COUNT; m_pc = 0; m_done = 0;
         end else begin
            m_mode = M_FIN; m_exp = 1; m_done = 1;
         end
      end else if (start && m_mode == M_FIN) begin
         m_q = m_reload; m_pc = 0;
         if (m_reload != 0) begin
            m_mode = M_COUNT; m_done = 0;
         end else begin
            m_exp = 1; m_done = 1;
         end
      end else if (m_mode == M_COUNT && !pause) begin
         if (m_pc >= int'(prescale)) begin
            m_pc = 0;
            if (m_q > 1) begin
               m_q = m_q - 1;
            end else begin
               m_exp = 1;
               if (auto_reload && m_reload != 0) begin
                  m_q = m_reload;
               end else begin
                  m_q = 0; m_done = 1; m_mode = M_FIN;
               end
            end
         end else begin
            m_pc = m_pc + 1;
         end
      end
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".q"}, int'(q), m_q);
      check({tag, ".busy"}, int'(busy), (m_mode == M_COUNT) ? 1 : 0);
      check({tag, ".expired"}, int'(expired), m_exp);
      check({tag, ".done"}, int'(done), m_done);
   endtask

   // One clock edge: advance the model, then sample the DUT 1 ns later.
   task automatic applyStimulus(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_outputs(tag);
   endtask

   task automatic clear_inputs();
      cl = 1'b0; w = 1'b0; start = 1'b0; pause = 1'b0;
   endtask

   initial begin
      int edges;
      int pulses;
      bit seen;

      rst_n = 1'b0; cl = 1'b0; w = 1'b0; d = '0; start = 1'b0;
      pause = 1'b0; auto_reload = 1'b0; prescale = '0;
      model_reset();
      #12;
      check_outputs("reset");
      rst_n = 1'b1;

      // Basic countdown from 5 with no prescaling.
      w = 1'b1; d = 8'd5;
      applyStimulus("load5");
      w = 1'b0; start = 1'b1;
      applyStimulus("start5");
      check("start5.q_lit", int'(q), 5);
      start = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         applyStimulus("count5");
         check("count5.q_lit", int'(q), 5 - k);
      end
      check("count5.expired_lit", int'(expired), 1);
      check("count5.done_lit", int'(done), 1);
      applyStimulus("after5");
      check("after5.expired_lit", int'(expired), 0);

      // Prescaled countdown: one tick every 4 edges.
      w = 1'b1; d = 8'd2; prescale = 3'd3;
      applyStimulus("load2");
      w = 1'b0; start = 1'b1;
      applyStimulus("start2");
      start = 1'b0;
      for (int k = 1; k <= 8; k++) applyStimulus("presc");
      check("presc.expired_lit", int'(expired), 1);
      start = 1'b1;
      applyStimulus("restart2");
      check("restart2.q_lit", int'(q), 2);
      check("restart2.busy_lit", int'(busy), 1);
      start = 1'b0;

      // Pause for 4 edges once the count reaches 7; expiry slips by 4 edges.
      prescale = '0; w = 1'b1; d = 8'd10;
      applyStimulus("load10");
      w = 1'b0; start = 1'b1;
      applyStimulus("start10");
      start = 1'b0;
      for (int k = 0; k < 3; k++) applyStimulus("pre_pause");
      pause = 1'b1;
      for (int k = 0; k < 4; k++) begin
         applyStimulus("paused");
         check("paused.q_lit", int'(q), 7);
      end
      pause = 1'b0;
      edges = 7;
      seen = 1'b0;
      while (!seen && edges < 40) begin
         applyStimulus("resume");
         edges++;
         seen = (expired === 1'b1);
      end
      check("pause.expiry_delay", edges - 10, 4);

      // Auto-reload: expiry every 3 edges, done stays low.
      auto_reload = 1'b1; w = 1'b1; d = 8'd3;
      applyStimulus("load3");
      w = 1'b0; start = 1'b1;
      applyStimulus("start3");
      start = 1'b0;
      pulses = 0;
      for (int k = 0; k < 9; k++) begin
         applyStimulus("reload");
         if (expired === 1'b1) pulses++;
      end
      check("reload.pulses", pulses, 3);
      check("reload.done_lit", int'(done), 0);
      auto_reload = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
         applyStimulus("reload_off");
         seen = (done === 1'b1);
      end
      check("reload_off.q_lit", int'(q), 0);

      // Priority and edge cases.
      w = 1'b1; d = 8'd20;
      applyStimulus("load20");
      w = 1'b0; start = 1'b1;
      applyStimulus("start20");
      start = 1'b0;
      applyStimulus("run20");
      cl = 1'b1; w = 1'b1; d = 8'd9;
      applyStimulus("cl_w");
      clear_inputs();
      w = 1'b1; d = 8'd20;
      applyStimulus("reload20");
      w = 1'b0; start = 1'b1;
      applyStimulus("restart20");
      start = 1'b0;
      applyStimulus("rerun20");
      w = 1'b1; d = 8'd9;
      applyStimulus("w_midrun");
      check("w_midrun.q_lit", int'(q), 9);
      w = 1'b0; cl = 1'b1;
      applyStimulus("cl");
      cl = 1'b0; start = 1'b1;
      applyStimulus("start_zero");
      check("start_zero.expired_lit", int'(expired), 1);
      start = 1'b0;

      // Asynchronous reset in the middle of a countdown.
      w = 1'b1; d = 8'd15;
      applyStimulus("load15");
      w = 1'b0; start = 1'b1;
      applyStimulus("start15");
      start = 1'b0;
      applyStimulus("run15");
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_outputs("async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus("post_reset");

      // Random stimulus against the model.
      for (int k = 0; k < 600; k++) begin
         @(negedge clk);
         cl          = ($urandom_range(0, 39) == 0);
         w           = ($urandom_range(0, 14) == 0);
         d           = WIDTH'($urandom_range(0, 12));
         start       = ($urandom_range(0, 5) == 0);
         pause       = ($urandom_range(0, 4) == 0);
         prescale    = PRESCALE_W'($urandom_range(0, 3));
         if ($urandom_range(0, 19) == 0) auto_reload = ~auto_reload;
         applyStimulus("random");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
